// File: rtl/hf_slot_arbiter.sv
// hf_slot_arbiter: time-slot scheduler that shares one block mover / MCU page path between
// NREQ requesters. A small/big carousel generates gigabit slots (small==0, small==GB1_SLOT),
// megabit slots (small==MB_SLOT with even big >= 4) and refresh triggers (small==0, odd big).
// Each accepted slot grants one requester and tracks one block-mover operation to completion.
// MCU refresh strobes are interleaved into idle cycles.
//
// Optional feature macro: HF_REFRESH_PRIORITY_EN. When defined, a saturated refresh backlog
// (three pending) blocks slot acceptance so the refresh goes first and the slot is dropped.
//
// Ports:
//   i_clk                 clock
//   i_rst                 synchronous active-high reset
//   i_req[NREQ]           level request per requester (0-1 gigabit, 2.. megabit)
//   o_grant[NREQ]         one-hot one-cycle grant pulse
//   o_done[NREQ]          one-hot one-cycle completion pulse
//   o_err                 one-cycle start-timeout pulse
//   o_active_id[2]        current/last granted requester
//   o_busy                high from grant to done/err inclusive
//   o_blck_issue          one-cycle issue pulse to the block mover
//   i_blck_working        block mover busy level
//   o_mcu_refresh_strobe  toggles once per refresh issued
module hf_slot_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned SMALL_LEN = 192,
  parameter int unsigned GB1_SLOT  = 96,
  parameter int unsigned MB_SLOT   = 2,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_grant,
  output logic [NREQ-1:0] o_done,
  output logic            o_err,
  output logic [1:0]      o_active_id,
  output logic            o_busy,
  output logic            o_blck_issue,
  input  logic            i_blck_working,
  output logic            o_mcu_refresh_strobe
);

  localparam int unsigned SW = (SMALL_LEN > 1) ? $clog2(SMALL_LEN) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0]   SMALL_LAST = SW'(SMALL_LEN - 1);
  localparam logic [SW-1:0]   GB1_VAL    = SW'(GB1_SLOT);
  localparam logic [SW-1:0]   MB_VAL     = SW'(MB_SLOT);
  localparam logic [CW-1:0]   CNT_LAST   = CW'(TIMEOUT - 1);
  localparam logic [NREQ-1:0] GB_MASK    = NREQ'(3);
  localparam logic [NREQ-1:0] MB_MASK    = ~GB_MASK;
  localparam logic [NREQ-1:0] ONE        = NREQ'(1);

  typedef enum logic [2:0] {StIdle, StGrant, StIssue, StWaitStart, StWaitEnd} state_t;

  state_t          r_state;
  logic [SW-1:0]   r_small;
  logic [3:0]      r_big;
  logic [1:0]      r_rr;
  logic [1:0]      r_pend;
  logic [CW-1:0]   r_cnt;
  logic            r_work_prev;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_done;
  logic            r_err;
  logic [1:0]      r_active_id;
  logic            r_busy;
  logic            r_issue;
  logic            r_strobe;

  logic            w_gb_trig;
  logic            w_mb_trig;
  logic            w_rfrs_trig;
  logic [NREQ-1:0] w_elig;
  logic            w_found;
  logic [1:0]      w_winner;
  int              w_dist;
  int              w_best;
  logic            w_hold;
  logic            w_accept;
  logic            w_refresh;

  assign w_gb_trig   = (r_small == '0) || (r_small == GB1_VAL);
  assign w_mb_trig   = (r_small == MB_VAL) && (r_big >= 4'd4) && !r_big[0];
  assign w_rfrs_trig = (r_small == '0) && r_big[0];
  assign w_elig      = w_gb_trig ? (i_req & GB_MASK) :
                       w_mb_trig ? (i_req & MB_MASK) : '0;

  // Round-robin: pick the eligible requester closest (circularly) at or after r_rr.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_dist   = 0;
    w_best   = int'(NREQ);
    for (int i = 0; i < int'(NREQ); i++) begin
      w_dist = (i + int'(NREQ) - int'(r_rr)) % int'(NREQ);
      if (w_elig[i] && (w_dist < w_best)) begin
        w_best   = w_dist;
        w_winner = 2'(i);
        w_found  = 1'b1;
      end
    end
  end

`ifdef HF_REFRESH_PRIORITY_EN
  assign w_hold = (r_pend == 2'd3);
`else
  assign w_hold = 1'b0;
`endif

  assign w_accept  = (r_state == StIdle) && w_found && !w_hold;
  assign w_refresh = (r_state == StIdle) && (r_pend != 2'd0) && !w_accept;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_small     <= '0;
      r_big       <= '0;
      r_rr        <= '0;
      r_pend      <= '0;
      r_cnt       <= '0;
      r_work_prev <= 1'b0;
      r_grant     <= '0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_active_id <= '0;
      r_busy      <= 1'b0;
      r_issue     <= 1'b0;
      r_strobe    <= 1'b0;
    end else begin
      if (r_small == SMALL_LAST) begin
        r_small <= '0;
        r_big   <= r_big + 4'd1;
      end else begin
        r_small <= r_small + 1'b1;
      end

      // A trigger and a refresh in the same cycle cancel out.
      if (w_rfrs_trig && !w_refresh) begin
        if (r_pend != 2'd3) r_pend <= r_pend + 2'd1;
      end else if (!w_rfrs_trig && w_refresh) begin
        r_pend <= r_pend - 2'd1;
      end
      if (w_refresh) r_strobe <= ~r_strobe;

      r_work_prev <= i_blck_working;
      r_grant     <= '0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_issue     <= 1'b0;

      unique case (r_state)
        StIdle: begin
          // Busy stays high through the done/err cycle, which is spent in idle.
          r_busy <= 1'b0;
          if (w_accept) begin
            r_state     <= StGrant;
            r_active_id <= w_winner;
            r_grant     <= ONE << w_winner;
            r_busy      <= 1'b1;
          end
        end
        StGrant: begin
          r_state <= StIssue;
          r_issue <= 1'b1;
        end
        StIssue: begin
          // r_cnt holds the number of cycles elapsed since the issue cycle.
          r_state <= StWaitStart;
          r_cnt   <= CW'(1);
        end
        StWaitStart: begin
          if (i_blck_working) begin
            r_state <= StWaitEnd;
          end else if (r_cnt >= CNT_LAST) begin
            r_err   <= 1'b1;
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StWaitEnd: begin
          if (r_work_prev && !i_blck_working) begin
            r_done  <= ONE << r_active_id;
            r_rr    <= (r_active_id == 2'(NREQ - 1)) ? 2'd0 : r_active_id + 2'd1;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_grant              = r_grant;
  assign o_done               = r_done;
  assign o_err                = r_err;
  assign o_active_id          = r_active_id;
  assign o_busy               = r_busy;
  assign o_blck_issue         = r_issue;
  assign o_mcu_refresh_strobe = r_strobe;

endmodule
